// File: rtl/cp0_ctrl_if.sv
// CP0 controller bus: M-stage control, MTC0/MFC0 access, interrupt lines and trap outputs.
// The master drives the pipeline side; the slave is the CP0 controller.
interface cp0_ctrl_if #(
  parameter int unsigned HW_INT_NUM = 6
);
  logic                  mtc0_en;
  logic [4:0]            addr;
  logic [31:0]           wdata;
  logic [31:0]           pc_M;
  logic [31:0]           badvaddr_M;
  logic [4:0]            exc_code;
  logic                  bd;
  logic                  eret;
  logic [HW_INT_NUM-1:0] hw_int;
  logic                  req;
  logic [31:0]           epc;
  logic [31:0]           rdata;
  logic                  timer_int;

  modport master (
    output mtc0_en, addr, wdata, pc_M, badvaddr_M, exc_code, bd, eret, hw_int,
    input  req, epc, rdata, timer_int
  );

  modport slave (
    input  mtc0_en, addr, wdata, pc_M, badvaddr_M, exc_code, bd, eret, hw_int,
    output req, epc, rdata, timer_int
  );
endinterface

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller beside the M stage: Status/Cause/EPC/BadVAddr/Count/Compare/PRId,
// interrupt vs. exception arbitration and the pipeline flush request.
module cp0_ctrl #(
  parameter int unsigned HW_INT_NUM = 6,
  parameter int unsigned COUNT_DIV  = 2,
  parameter int unsigned TIMER_IP   = 7,
  parameter logic [31:0] PRID       = 32'h0000_4220
) (
  input logic        clk,
  input logic        reset,
  cp0_ctrl_if.slave  bus
);

  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;
  localparam logic [4:0] AddrPrid     = 5'd15;
  localparam logic [4:0] ExcAdEL      = 5'd4;
  localparam logic [4:0] ExcAdES      = 5'd5;
  localparam logic [4:0] PrescMax     = 5'(COUNT_DIV - 1);
  localparam logic [2:0] TimerBit     = 3'(TIMER_IP);

  logic [HW_INT_NUM-1:0] r_sync1;
  logic [HW_INT_NUM-1:0] r_sync2;
  logic                  r_ie;
  logic                  r_exl;
  logic [7:0]            r_im;
  logic [1:0]            r_ip_sw;
  logic                  r_bd;
  logic                  r_ti;
  logic [4:0]            r_exc_code;
  logic [31:0]           r_epc;
  logic [31:0]           r_badvaddr;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [4:0]            r_presc;

  logic [5:0]  w_hw_ext;
  logic [7:0]  w_ip;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic        w_tick;
  logic [31:0] w_count_inc;
  logic        w_ti_set;
  logic        w_addr_err;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_rdata;

  assign w_hw_ext = 6'(r_sync2);

  always_comb begin
    w_ip           = {w_hw_ext, r_ip_sw};
    w_ip[TimerBit] = w_ip[TimerBit] | r_ti;
  end

  // Interrupts outrank exceptions; nothing is taken while EXL is set.
  assign w_int_req = (|(w_ip & r_im)) & r_ie & ~r_exl;
  assign w_exc_req = (bus.exc_code != 5'd0) & ~w_int_req & ~r_exl;
  assign w_req     = w_int_req | w_exc_req;

  assign w_wr         = bus.mtc0_en & ~w_req;
  assign w_wr_count   = w_wr & (bus.addr == AddrCount);
  assign w_wr_compare = w_wr & (bus.addr == AddrCompare);
  assign w_wr_status  = w_wr & (bus.addr == AddrStatus);
  assign w_wr_cause   = w_wr & (bus.addr == AddrCause);
  assign w_wr_epc     = w_wr & (bus.addr == AddrEpc);

  assign w_tick      = (r_presc == PrescMax);
  assign w_count_inc = r_count + 32'd1;
  // Only an increment landing on Compare raises TI; a write that creates equality does not.
  assign w_ti_set    = w_tick & ~w_wr_count & (w_count_inc == r_compare);
  assign w_addr_err  = w_exc_req & ((bus.exc_code == ExcAdEL) | (bus.exc_code == ExcAdES));

  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exc_code, 2'b0};

  always_comb begin
    w_rdata = 32'h0;
    case (bus.addr)
      AddrBadVAddr: w_rdata = r_badvaddr;
      AddrCount:    w_rdata = r_count;
      AddrCompare:  w_rdata = r_compare;
      AddrStatus:   w_rdata = w_status;
      AddrCause:    w_rdata = w_cause;
      AddrEpc:      w_rdata = r_epc;
      AddrPrid:     w_rdata = PRID;
      default:      w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.hw_int;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_im       <= 8'h00;
      r_ip_sw    <= 2'b00;
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
      r_epc      <= 32'h0;
    end else begin
      if (w_req) begin
        r_exl      <= 1'b1;
        r_bd       <= bus.bd;
        r_epc      <= bus.bd ? (bus.pc_M - 32'd4) : bus.pc_M;
        r_exc_code <= w_int_req ? 5'd0 : bus.exc_code;
      end else begin
        if (bus.eret) begin
          r_exl <= 1'b0;
        end else if (w_wr_status) begin
          r_exl <= bus.wdata[1];
        end
        if (w_wr_epc) begin
          r_epc <= bus.wdata;
        end
      end
      if (w_wr_status) begin
        r_ie <= bus.wdata[0];
        r_im <= bus.wdata[15:8];
      end
      if (w_wr_cause) begin
        r_ip_sw <= bus.wdata[9:8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_badvaddr <= 32'h0;
    end else if (w_addr_err) begin
      // A misaligned fetch address is the faulting one; otherwise the data address.
      r_badvaddr <= (bus.pc_M[1:0] != 2'b00) ? bus.pc_M : bus.badvaddr_M;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= 32'h0;
      r_presc   <= 5'd0;
      r_compare <= 32'h0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= bus.wdata;
        r_presc <= 5'd0;
      end else if (w_tick) begin
        r_count <= w_count_inc;
        r_presc <= 5'd0;
      end else begin
        r_presc <= r_presc + 5'd1;
      end
      if (w_wr_compare) begin
        r_compare <= bus.wdata;
        r_ti      <= 1'b0;
      end else if (w_ti_set) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign bus.req       = w_req;
  assign bus.epc       = r_epc;
  assign bus.rdata     = w_rdata;
  assign bus.timer_int = r_ti;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: vector table, directed corner sequences and randomized
// traffic compared against an architectural model of the CP0 registers.
module tb_cp0_ctrl;

  localparam int unsigned HwIntNum = 6;
  localparam int unsigned CountDiv = 2;
  localparam int unsigned TimerIp  = 7;
  localparam logic [31:0] Prid     = 32'h0000_4220;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  cp0_ctrl_if #(.HW_INT_NUM(HwIntNum)) bus ();

  cp0_ctrl #(
    .HW_INT_NUM(HwIntNum),
    .COUNT_DIV (CountDiv),
    .TIMER_IP  (TimerIp),
    .PRID      (Prid)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model state
  logic        m_ie, m_exl, m_bd, m_ti;
  logic [7:0]  m_im;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_bva, m_count, m_cmp;
  int          m_phase;
  logic [5:0]  m_hist [2];  // [0] = hw_int one edge ago, [1] = two edges ago

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_im = 0; m_ipsw = 0; m_exc = 0;
    m_epc = 0; m_bva = 0; m_count = 0; m_cmp = 0; m_phase = 0;
    m_hist[0] = 0; m_hist[1] = 0;
  endtask

  function automatic logic [7:0] m_ip();
    logic [7:0] ip;
    ip = {m_hist[1], m_ipsw};
    if (m_ti) ip[TimerIp] = 1'b1;
    return ip;
  endfunction

  function automatic logic m_int_req();
    return ((m_ip() & m_im) != 8'h00) && m_ie && !m_exl;
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((bus.exc_code != 5'd0) && !m_exl);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8)
                      | (32'(m_exc) << 2);
      5'd14:   return m_epc;
      5'd15:   return Prid;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic ir, rq, wr, hit;
    ir  = m_int_req();
    rq  = m_req();
    wr  = bus.mtc0_en && !rq;
    hit = 1'b0;
    if (wr && bus.addr == 5'd9) begin
      m_count = bus.wdata;
      m_phase = 0;
    end else if (m_phase + 1 == CountDiv) begin
      m_phase = 0;
      m_count = m_count + 32'd1;
      hit     = (m_count == m_cmp);
    end else begin
      m_phase++;
    end
    if (wr && bus.addr == 5'd11) begin
      m_cmp = bus.wdata;
      m_ti  = 1'b0;
    end else if (hit) begin
      m_ti = 1'b1;
    end
    if (rq) begin
      m_exl = 1'b1;
      m_bd  = bus.bd;
      m_epc = bus.bd ? bus.pc_M - 32'd4 : bus.pc_M;
      m_exc = ir ? 5'd0 : bus.exc_code;
      if (!ir && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5))
        m_bva = (bus.pc_M[1:0] != 2'b00) ? bus.pc_M : bus.badvaddr_M;
    end else if (bus.eret) begin
      m_exl = 1'b0;
    end else if (wr && bus.addr == 5'd12) begin
      m_exl = bus.wdata[1];
    end
    if (wr && bus.addr == 5'd12) begin
      m_ie = bus.wdata[0];
      m_im = bus.wdata[15:8];
    end
    if (wr && bus.addr == 5'd13) m_ipsw = bus.wdata[9:8];
    if (wr && bus.addr == 5'd14) m_epc = bus.wdata;
    m_hist[1] = m_hist[0];
    m_hist[0] = bus.hw_int;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic [4:0] a, input logic [31:0] wd,
                        input logic [4:0] exc, input logic [31:0] pc, input logic [31:0] bva,
                        input logic bdi, input logic er);
    bus.mtc0_en = en; bus.addr = a; bus.wdata = wd; bus.exc_code = exc;
    bus.pc_M = pc; bus.badvaddr_M = bva; bus.bd = bdi; bus.eret = er;
  endtask

  task automatic idle(input logic [4:0] a);
    set_in(1'b0, a, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic settle();
    #1;
    check("model_req", 32'(bus.req), 32'(m_req()));
    check("model_epc", bus.epc, m_epc);
    check("model_ti", 32'(bus.timer_int), 32'(m_ti));
    check("model_rdata", bus.rdata, m_rdata(bus.addr));
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic [31:0] bva;
    logic        bd;
    logic        eret;
    logic        exp_req;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [20];
  logic [4:0]  pool [8];
  logic [4:0]  r_a, r_exc;
  logic [31:0] r_wd, r_pc;
  logic [5:0]  r_hw;
  logic        r_en;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.hw_int = '0;
    idle(5'd0);
    model_reset();

    vecs[0]  = '{0, 12, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0040_0000};
    vecs[1]  = '{1, 12, 32'h1,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0040_0000};
    vecs[2]  = '{0, 12, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0040_0001};
    vecs[3]  = '{0, 13, 32'h0,        4,  32'h8000_0100, 32'h1003, 1, 0, 1, 32'h0};
    vecs[4]  = '{0, 13, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h8000_0010};
    vecs[5]  = '{0, 14, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h8000_00FC};
    vecs[6]  = '{0, 8,  32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0000_1003};
    vecs[7]  = '{0, 12, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0040_0003};
    vecs[8]  = '{0, 13, 32'h0,        10, 32'h8000_0300, 32'h55,   0, 0, 0, 32'h8000_0010};
    vecs[9]  = '{0, 13, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h8000_0010};
    vecs[10] = '{0, 12, 32'h0,        0,  32'h0,         32'h0,    0, 1, 0, 32'h0040_0003};
    vecs[11] = '{0, 12, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0040_0001};
    vecs[12] = '{0, 15, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0000_4220};
    vecs[13] = '{0, 3,  32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0};
    vecs[14] = '{1, 3,  32'hFFFF,     0,  32'h0,         32'h0,    0, 0, 0, 32'h0};
    vecs[15] = '{0, 8,  32'h0,        5,  32'h8000_0202, 32'h44,   0, 0, 1, 32'h0000_1003};
    vecs[16] = '{0, 8,  32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h8000_0202};
    vecs[17] = '{0, 14, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h8000_0202};
    vecs[18] = '{0, 13, 32'h0,        0,  32'h0,         32'h0,    0, 0, 0, 32'h0000_0014};
    vecs[19] = '{0, 12, 32'h0,        0,  32'h0,         32'h0,    0, 1, 0, 32'h0040_0003};

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].en, vecs[i].addr, vecs[i].wdata, vecs[i].exc, vecs[i].pc, vecs[i].bva,
             vecs[i].bd, vecs[i].eret);
      settle();
      check($sformatf("vec%0d_req", i), 32'(bus.req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rdata);
      advance();
    end

    // Synchronised interrupt beats a simultaneous exception.
    set_in(1'b1, 5'd12, 32'h0000_0401, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    settle(); advance();
    idle(5'd13);
    bus.hw_int = 6'b000001;
    settle(); check("int_t0", 32'(bus.req), 32'd0); advance();
    settle(); check("int_t1", 32'(bus.req), 32'd0); advance();
    set_in(1'b0, 5'd13, 32'h0, 5'd12, 32'h8000_1000, 32'h0, 1'b0, 1'b0);
    settle(); check("int_t2", 32'(bus.req), 32'd1); advance();
    bus.hw_int = 6'b000000;
    idle(5'd13);
    settle(); check("int_cause", bus.rdata, 32'h0000_0400);
    check("int_epc", bus.epc, 32'h8000_1000); advance();
    idle(5'd12);
    settle(); check("int_status_exl", bus.rdata, 32'h0040_0403); advance();
    settle(); advance();
    set_in(1'b0, 5'd12, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    settle(); advance();
    idle(5'd12);
    settle(); check("eret_status", bus.rdata, 32'h0040_0401);
    check("eret_req", 32'(bus.req), 32'd0); advance();

    // Timer match after ten cycles with COUNT_DIV = 2.
    set_in(1'b1, 5'd12, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); settle(); advance();
    set_in(1'b1, 5'd11, 32'd5, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); settle(); advance();
    set_in(1'b1, 5'd9,  32'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); settle(); advance();
    idle(5'd13);
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("ti_early%0d", i), 32'(bus.timer_int), 32'd0);
      advance();
    end
    settle(); check("ti_set", 32'(bus.timer_int), 32'd1);
    check("ti_cause", bus.rdata, 32'h4000_8000); advance();
    set_in(1'b1, 5'd11, 32'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); settle(); advance();
    idle(5'd13);
    settle(); check("ti_clr", 32'(bus.timer_int), 32'd0);
    check("ti_clr_cause", bus.rdata, 32'h0); advance();

    // Count wrap matches Compare = 0; MTC0 alongside an exception is dropped.
    set_in(1'b1, 5'd11, 32'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); settle(); advance();
    set_in(1'b1, 5'd9, 32'hFFFF_FFFF, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); settle(); advance();
    idle(5'd9);
    settle(); check("wrap_pre", bus.rdata, 32'hFFFF_FFFF); advance();
    set_in(1'b1, 5'd12, 32'h0000_FF03, 5'd8, 32'h8000_2000, 32'h0, 1'b0, 1'b0);
    settle(); check("wrap_req", 32'(bus.req), 32'd1); advance();
    idle(5'd9);
    settle(); check("wrap_count", bus.rdata, 32'h0);
    check("wrap_ti", 32'(bus.timer_int), 32'd1); advance();
    idle(5'd13);
    settle(); check("wrap_cause", bus.rdata, 32'h4000_8020); advance();
    idle(5'd12);
    settle(); check("wrap_status", bus.rdata, 32'h0040_0002);
    check("wrap_epc", bus.epc, 32'h8000_2000); advance();

    // Asynchronous reset mid-cycle clears pending TI and EPC at once.
    #2 reset = 1'b1;
    #1;
    check("rst_epc", bus.epc, 32'h0);
    check("rst_ti", 32'(bus.timer_int), 32'd0);
    check("rst_status", bus.rdata, 32'h0040_0000);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(5'd9);
    settle(); check("rst_count", bus.rdata, 32'h0); advance();

    // Randomized traffic against the model.
    pool[0] = 5'd8;  pool[1] = 5'd9;  pool[2] = 5'd11; pool[3] = 5'd12;
    pool[4] = 5'd13; pool[5] = 5'd14; pool[6] = 5'd15; pool[7] = 5'd2;
    for (int c = 0; c < 500; c++) begin
      r_a  = pool[$urandom_range(0, 7)];
      r_en = ($urandom_range(0, 3) == 0);
      r_wd = $urandom;
      if (r_a == 5'd9) r_wd = m_cmp - 32'($urandom_range(1, 6));
      if (r_a == 5'd11 && $urandom_range(0, 1) == 1) r_wd = m_count + 32'($urandom_range(1, 8));
      r_exc = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      r_pc  = $urandom;
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      set_in(r_en, r_a, r_wd, r_exc, r_pc, $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) begin
        r_hw = bus.hw_int;
        r_hw[$urandom_range(0, 5)] = ~r_hw[$urandom_range(0, 5)];
        bus.hw_int = r_hw;
      end
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Parametrised coprocessor-0 controller for the 5-stage MIPS pipeline, sitting beside the M stage. It holds Status, Cause, EPC, BadVAddr, Count, Compare and PRId, arbitrates interrupts against M-stage exceptions, and raises `req` to flush the pipeline. Compared with the previous block it adds:
- a configurable hardware-interrupt count with 2-flop input synchronisers;
- a Count prescaler;
- timer-interrupt routing to a selectable IP bit;
- explicit `eret` handling;
- an edge-qualified timer match.

## Interface
Reset is asynchronous and active-high; one clock.

Parameters:
- HW_INT_NUM, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2+i]
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (1..16)
- TIMER_IP, 7, Cause.IP bit that the timer flag ORs into (2..7)
- PRID, 32'h0000_4220, read-only PRId value

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mtc0_en  in  1  MTC0 write strobe from M stage
- addr  in  5  CP0 register number, used for both read and write
- wdata  in  32  MTC0 data
- pc_M  in  32  PC of the M-stage instruction
- badvaddr_M  in  32  data address of the M-stage load/store
- exc_code  in  5  M-stage exception code; 0 = none
- bd  in  1  M-stage instruction is in a delay slot
- eret  in  1  ERET in M stage
- hw_int  in  HW_INT_NUM  asynchronous external interrupt lines
- req  out  1  exception/interrupt taken this cycle
- epc  out  32  current EPC
- rdata  out  32  MFC0 read data, combinational on addr
- timer_int  out  1  Cause.TI

## Operation
Register numbers:
- BadVAddr = 8, Count = 9, Compare = 11, Status = 12, Cause = 13, EPC = 14, PRId = 15.
- Any other address reads 0, and writes to it are ignored.

Status layout: `{9'b0, BEV, 6'b0, IM[7:0], 6'b0, EXL, IE}`.
- BEV is hardwired 1.
- IM, EXL and IE are writable.

Cause layout: `{BD, TI, 14'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b0}`.
- Only IP[1:0] (software interrupts) are writable.

Request logic:
- int_req = |(IP & IM) & IE & ~EXL.
- exc_req = (exc_code != 0) & ~int_req & ~EXL.
- req = int_req | exc_req. Interrupts have priority over exceptions.

Write enable:
- wr = mtc0_en & ~req. An MTC0 in the same cycle as req is dropped.

On req:
- EXL <= 1.
- BD <= bd.
- EPC <= bd ? pc_M-4 : pc_M.
- ExcCode <= int_req ? 0 : exc_code.

On exc_req with exc_code 4 (AdEL) or 5 (AdES):
- BadVAddr <= pc_M when pc_M[1:0] != 0, else badvaddr_M.

No other exception changes BadVAddr.

EXL update priority: req sets, then eret clears, then a wr to Status loads wdata[1].

External interrupts:
- hw_int[i] passes through two flops; the second flop drives IP[2+i].
- IP bits at index ≥ 2+HW_INT_NUM read 0.
- IP[TIMER_IP] = sync value (if mapped) | TI.

Timer:
- A prescaler counts 0..COUNT_DIV-1.
- Count increments (mod 2^32) in the cycle the prescaler is at COUNT_DIV-1.
- A wr to Count loads wdata and clears the prescaler.
- TI sets in the cycle Count increments to a value equal to Compare.
- A wr to Compare loads it and clears TI, taking priority over a same-cycle set.
- An equality caused by a write alone does not set TI.

## Timing
Reset values (all outputs and registers):
- EXL = IE = IM = 0.
- Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0, prescaler = 0, synchronisers = 0.
- Therefore req = 0, epc = 0, timer_int = 0.
- Reset asserted mid-operation clears all of the above immediately, including any pending TI.

Latencies:
- req, rdata: combinational, same cycle.
- Register updates: visible on the next clk edge.
- hw_int edge to req: 2 edges of the synchroniser, then combinational.
- TI: visible one edge after the matching increment; req follows the same cycle, if enabled.

Boundary cases:
- Count at 32'hFFFF_FFFF wraps to 0. A match at Compare = 0 sets TI.
- COUNT_DIV = 1: Count increments every cycle.
- req while EXL = 1: impossible by construction; exceptions are ignored while EXL = 1.
- eret and req in the same cycle: EXL remains 1, EPC updates.

## Test plan
- Reset released, hw_int = 0 -> Status reads 32'h0040_0000, Cause/EPC/Count read 0, req = 0 for 20 cycles.
- Status = 32'h0000_0401, hw_int[0] rises at cycle t -> req = 1 at cycle t+2; then Cause.ExcCode = 0, EXL = 1, EPC = pc_M; eret clears EXL.
- Data address error: exc_code = 4, pc_M = 32'h8000_0100, badvaddr_M = 32'h1003, bd = 1 -> req = 1, EPC = 32'h8000_00FC, BadVAddr = 32'h1003, Cause = 32'h8000_0010.
- COUNT_DIV = 2, Compare = 5, Count = 0 -> TI and IP[7] set after the 10th cycle; write Compare = 9 -> TI cleared next edge.
- Count = 32'hFFFF_FFFF, Compare = 0 -> Count wraps to 0 and TI sets; MTC0 Status with exc_code = 8 in the same cycle -> write dropped, ExcCode = 8.
- Interrupt and exception together with IE = 1 and an unmasked IP -> ExcCode = 0 (interrupt wins); with EXL = 1 and exc_code = 10 -> req = 0, no register change.
